// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_mem
// Description : Shared dual-port word memory. Two independent ports each
//               write and read one word per cycle. Reads are registered and
//               return pre-write data for same-cycle collisions. Port 1 wins
//               when both ports write one address. Synchronous reset clears
//               both outputs and every memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem #(
   parameter int Ncores = 2,
   parameter int Lmem   = 8,
   parameter int TAM    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [0:TAM-1]    dataIN0,
   input  logic [0:TAM-1]    dataIN1,
   input  logic [0:TAM-1]    dataADDR0,
   input  logic [0:TAM-1]    dataADDR1,
   input  logic [0:Ncores-1] dataWrite,
   input  logic [0:Ncores-1] dataLoad,
   output logic [0:TAM-1]    dataOUT0,
   output logic [0:TAM-1]    dataOUT1
);

   localparam int c_DEPTH = 1 << Lmem;

   // Index 0 is the MSB on every bus, so the word address is the tail slice.
   logic [Lmem-1:0] w_addr0;
   logic [Lmem-1:0] w_addr1;

   logic [0:TAM-1] r_mem [0:c_DEPTH-1];
   logic [0:TAM-1] r_out0;
   logic [0:TAM-1] r_out1;

   assign w_addr0 = dataADDR0[TAM-Lmem:TAM-1];
   assign w_addr1 = dataADDR1[TAM-Lmem:TAM-1];

   // Upper address bits are deliberately ignored so addresses wrap.
   generate
      if (Lmem < TAM) begin : g_unusedAddr
         logic w_unusedUpper;
         assign w_unusedUpper = ^{dataADDR0[0:TAM-Lmem-1], dataADDR1[0:TAM-Lmem-1]};
      end
   endgenerate

   // Storage update; port 1 is assigned last so it wins a same-address write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (dataWrite[0]) begin
            r_mem[w_addr0] <= dataIN0;
         end
         if (dataWrite[1]) begin
            r_mem[w_addr1] <= dataIN1;
         end
      end
   end

   // Registered reads sample the array before this edge's writes land.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out0 <= '0;
         r_out1 <= '0;
      end else begin
         if (dataLoad[0]) begin
            r_out0 <= r_mem[w_addr0];
         end
         if (dataLoad[1]) begin
            r_out1 <= r_mem[w_addr1];
         end
      end
   end

   assign dataOUT0 = r_out0;
   assign dataOUT1 = r_out1;

endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem
// Description : Scoreboard bench for data_mem. A driver issues operations and
//               pushes expected read data from an array model; a monitor pops
//               and compares whenever a read completes, and checks that the
//               outputs hold otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem;

   logic        clk;
   logic        rst;
   logic [0:15] dataIN0;
   logic [0:15] dataIN1;
   logic [0:15] dataADDR0;
   logic [0:15] dataADDR1;
   logic [0:1]  dataWrite;
   logic [0:1]  dataLoad;
   logic [0:15] dataOUT0;
   logic [0:15] dataOUT1;

   int checks   = 0;
   int failures = 0;

   logic [15:0] model [0:255];
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];

   data_mem #(.Ncores(2), .Lmem(8), .TAM(16)) dut (
      .clk(clk), .rst(rst),
      .dataIN0(dataIN0), .dataIN1(dataIN1),
      .dataADDR0(dataADDR0), .dataADDR1(dataADDR1),
      .dataWrite(dataWrite), .dataLoad(dataLoad),
      .dataOUT0(dataOUT0), .dataOUT1(dataOUT1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // One operation per cycle; the model reads before it writes and port 1 writes last.
   task automatic cyc(input logic r, input logic w0, input logic w1,
                      input logic l0, input logic l1,
                      input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1);
      @(negedge clk);
      rst = r;
      dataWrite[0] = w0; dataWrite[1] = w1;
      dataLoad[0]  = l0; dataLoad[1]  = l1;
      dataADDR0 = a0; dataADDR1 = a1;
      dataIN0 = d0; dataIN1 = d1;
      if (r) begin
         foreach (model[i]) model[i] = 16'h0000;
      end else begin
         if (l0) q0.push_back(model[a0 % 256]);
         if (l1) q1.push_back(model[a1 % 256]);
         if (w0) model[a0 % 256] = d0;
         if (w1) model[a1 % 256] = d1;
      end
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
   endtask

   // Monitor: note at each edge whether a read or reset took effect.
   logic mLd0 = 1'b0, mLd1 = 1'b0, mRst = 1'b0, armed = 1'b0;
   logic [15:0] last0 = 16'h0, last1 = 16'h0;

   always @(posedge clk) begin
      mRst <= rst;
      mLd0 <= dataLoad[0] & ~rst;
      mLd1 <= dataLoad[1] & ~rst;
   end

   always @(negedge clk) begin
      logic [15:0] e;
      if (mRst) begin
         checks++;
         if (dataOUT0 !== 16'h0) begin
            failures++;
            $display("FAIL reset_out0: got %h required 0000", dataOUT0);
         end
         checks++;
         if (dataOUT1 !== 16'h0) begin
            failures++;
            $display("FAIL reset_out1: got %h required 0000", dataOUT1);
         end
         last0 = 16'h0; last1 = 16'h0; armed = 1'b1;
      end else if (armed) begin
         if (mLd0) begin
            checks++;
            if (q0.size() == 0) begin
               failures++;
               $display("FAIL read0_queue: got empty required entry");
            end else begin
               e = q0.pop_front();
               if (dataOUT0 !== e) begin
                  failures++;
                  $display("FAIL read0: got %h required %h", dataOUT0, e);
               end
               last0 = e;
            end
         end else begin
            checks++;
            if (dataOUT0 !== last0) begin
               failures++;
               $display("FAIL hold0: got %h required %h", dataOUT0, last0);
            end
         end
         if (mLd1) begin
            checks++;
            if (q1.size() == 0) begin
               failures++;
               $display("FAIL read1_queue: got empty required entry");
            end else begin
               e = q1.pop_front();
               if (dataOUT1 !== e) begin
                  failures++;
                  $display("FAIL read1: got %h required %h", dataOUT1, e);
               end
               last1 = e;
            end
         end else begin
            checks++;
            if (dataOUT1 !== last1) begin
               failures++;
               $display("FAIL hold1: got %h required %h", dataOUT1, last1);
            end
         end
      end
   end

   initial begin
      logic [15:0] a0, a1;
      rst = 1'b1; dataWrite = 2'b00; dataLoad = 2'b00;
      dataADDR0 = 16'h0; dataADDR1 = 16'h0; dataIN0 = 16'h0; dataIN1 = 16'h0;

      // Reset, then both ports read zero.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0042, 16'h00FF, 16'h0, 16'h0);

      // Directed dual write then dual read.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0034, 16'hBEEF, 16'h1234);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0012, 16'h0034, 16'h0, 16'h0);
      idle();

      // Same-address double write: port 1 wins.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0005, 16'hAAAA, 16'h5555);
      idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0105, 16'h0, 16'h0);

      // Address wrap across ports.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0107, 16'h0, 16'h0001, 16'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0007, 16'h0, 16'h0);

      // Read-before-write across ports, then new data visible.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0, 16'h1111, 16'h0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h0003, 16'h2222, 16'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 16'h0003, 16'h0, 16'h0);

      // Same-port write and load together.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0003, 16'h0, 16'h3333);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0003, 16'h0, 16'h0);

      // Reset priority: writes and loads in a reset cycle are ignored, memory cleared.
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0012, 16'h0040, 16'h7777, 16'h8888);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0012, 16'h0040, 16'h0, 16'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 16'h0034, 16'h0, 16'h0);

      // Alternating random write/load cycles; small address pool with random upper bits.
      for (int i = 0; i < 1000; i++) begin
         a0 = 16'(($urandom & 16'hFF00) | $urandom_range(0, 31));
         a1 = 16'(($urandom & 16'hFF00) | $urandom_range(0, 31));
         cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, a0, a1, 16'($urandom), 16'($urandom));
         a0 = 16'(($urandom & 16'hFF00) | $urandom_range(0, 31));
         a1 = 16'(($urandom & 16'hFF00) | $urandom_range(0, 31));
         cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a0, a1, 16'($urandom), 16'($urandom));
      end

      // Fully random mixed operations, including occasional reset.
      for (int i = 0; i < 600; i++) begin
         a0 = 16'(($urandom & 16'hFF00) | $urandom_range(0, 15));
         a1 = 16'(($urandom & 16'hFF00) | $urandom_range(0, 15));
         cyc(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), a0, a1, 16'($urandom), 16'($urandom));
      end

      idle();
      idle();
      idle();
      @(negedge clk);
      #1;
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d/%0d pending required 0/0", q0.size(), q1.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter Ncores, default 2, number of core ports; the port list is fixed at two, so only Ncores=2 is supported.
REQ-002 Parameter Lmem, default 8, address width in bits; depth is 2^Lmem words (256).
REQ-003 Parameter TAM, default 16, data and address bus width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 dataIN0  input  TAM [0:TAM-1]  write data, port 0.
REQ-007 dataIN1  input  TAM [0:TAM-1]  write data, port 1.
REQ-008 dataADDR0  input  TAM [0:TAM-1]  word address, port 0.
REQ-009 dataADDR1  input  TAM [0:TAM-1]  word address, port 1.
REQ-010 dataWrite  input  Ncores [0:Ncores-1]  write enable; bit 0 = port 0, bit 1 = port 1.
REQ-011 dataLoad  input  Ncores [0:Ncores-1]  read enable; bit 0 = port 0, bit 1 = port 1.
REQ-012 dataOUT0  output  TAM [0:TAM-1]  registered read data, port 0.
REQ-013 dataOUT1  output  TAM [0:TAM-1]  registered read data, port 1.
REQ-014 All buses SHALL use ascending [0:N-1] ranges, with index 0 the MSB.

Function
REQ-015 Storage SHALL be an array of 2^Lmem words, each TAM bits wide, shared by both ports.
REQ-016 Each port SHALL use only the Lmem LSBs of its address (bits [TAM-Lmem:TAM-1]); upper bits are ignored, so addresses wrap modulo 2^Lmem.
REQ-017 Writes: on a rising edge with dataWrite[k]=1 and rst=0, mem[addr_k] SHALL take dataINk.
REQ-018 Reads: on a rising edge with dataLoad[k]=1 and rst=0, dataOUTk SHALL take mem[addr_k].
REQ-019 Read latency SHALL be 1 cycle: read data appears after the enabling edge and is stable through the following clock low phase.
REQ-020 With dataLoad[k]=0, dataOUTk SHALL hold its previous value.
REQ-021 A read and a write in the same cycle to the same address, on the same or the other port, SHALL return the old (pre-write) data (read-before-write).
REQ-022 A write followed by a read of the same address in the next cycle SHALL return the newly written data.
REQ-023 If both ports write the same address in the same cycle, the port 1 data SHALL be stored.
REQ-024 Both ports SHALL operate fully independently and concurrently when their addresses differ.
REQ-025 dataWrite and dataLoad both high on one port SHALL perform both operations, following REQ-021.
REQ-026 The design SHALL contain no combinational path from inputs to outputs.

Reset
REQ-027 On a rising edge with rst=1, dataOUT0 and dataOUT1 SHALL become 0 and every memory word SHALL become 0.
REQ-028 Reset SHALL take priority: any write or read enabled in a reset cycle is ignored.
REQ-029 Operation SHALL resume on the first rising edge with rst=0.
REQ-030 Before the first reset, memory and output contents SHALL be undefined.

Verification
REQ-031 Apply rst=1 for one edge -> dataOUT0=dataOUT1=0; then dataLoad=2'b11 at any address -> both outputs read 0.
REQ-032 Write cycle: ADDR0=0x0012 with IN0=0xBEEF, ADDR1=0x0034 with IN1=0x1234, dataWrite=2'b11. Next cycle: dataLoad=2'b11 at the same addresses -> at the following negedge, dataOUT0=0xBEEF and dataOUT1=0x1234.
REQ-033 Alternate write/load cycles with random 16-bit data and random 8-bit addresses for 1000 iterations -> each output equals the data last written to its address.
REQ-034 Both ports write address 0x05 in one cycle (IN0=0xAAAA, IN1=0x5555) -> a later read of 0x05 returns 0x5555.
REQ-035 Write 0x0001 to ADDR0=0x0107; then read ADDR1=0x0007 -> dataOUT1=0x0001, confirming the address wrap.
REQ-036 Write 0x1111 to address 3; in one cycle, port 0 writes 0x2222 to address 3 while port 1 loads address 3 -> dataOUT1=0x1111; a read in the next cycle -> 0x2222.
